// File: rtl/synapse_scheduler_pkg.sv
// Shared neuron datapath definitions: scheduler state encoding and the
// accumulator width that input_align is built for.
package neuron_pkg;

    localparam int unsigned W_DEFAULT = 11;
    localparam int unsigned STEP_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2
    } sched_state_e;

endpackage

// File: rtl/synapse_scheduler_if.sv
// Requester-side bus of the synapse scheduler: spike requests and weights in,
// grants and the accumulator feed out.
interface synapse_scheduler_if #(
    parameter int unsigned NUM_SYN = 4,
    parameter int unsigned W       = 11
);
    logic [NUM_SYN-1:0]   req;
    logic [NUM_SYN*W-1:0] weight;
    logic [NUM_SYN-1:0]   grant;
    logic [W-1:0]         syn_out;
    logic                 align_en;
    logic                 ovf;

    modport master (
        output req, weight,
        input  grant, syn_out, align_en, ovf
    );

    modport slave (
        input  req, weight,
        output grant, syn_out, align_en, ovf
    );
endinterface

// File: rtl/synapse_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// counting upward with wrap.
module rr_arbiter #(
    parameter int unsigned NUM_SYN = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_SYN-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_SYN-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_SYN; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % NUM_SYN);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/synapse_scheduler.sv
// Shares the input_align accumulator among NUM_SYN requesters over fixed
// integration windows, with a spike-free flush cycle at each boundary.
module synapse_scheduler
    import neuron_pkg::*;
#(
    parameter int unsigned NUM_SYN = 4,
    parameter int unsigned W       = W_DEFAULT,
    parameter int unsigned WINDOW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic [STEP_W-1:0] step,
    synapse_scheduler_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1;
    localparam int unsigned CNT_W = $clog2(WINDOW);
    localparam int unsigned SUM_W = W + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = {1'b0, {W{1'b1}}};

    sched_state_e       state_q, state_d;
    logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               stop_q, stop_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [NUM_SYN-1:0] grant_q, grant_d;
    logic [W-1:0]       syn_q, syn_d;
    logic               align_q, align_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic [STEP_W-1:0]  step_q, step_d;

    logic [NUM_SYN-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [SUM_W:0]     sum_wide;

    rr_arbiter #(
        .NUM_SYN (NUM_SYN),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Next-state, arbitration, shadow sum and registered-output inputs
    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        ptr_d     = ptr_q;
        stop_d    = stop_q;
        sum_d     = '0;
        grant_d   = '0;
        syn_d     = '0;
        align_d   = 1'b0;
        ovf_d     = 1'b0;
        busy_d    = 1'b0;
        step_d    = step_q;
        sum_wide  = {1'b0, sum_q} + (SUM_W+1)'(syn_q);

        if (state_q == ST_COLLECT) begin
            sum_d = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_COLLECT;
                    win_cnt_d = '0;
                    stop_d    = stop;
                end
            end
            ST_COLLECT: begin
                stop_d    = stop_q | stop;
                win_cnt_d = win_cnt_q + 1'b1;
                if (win_cnt_q == CNT_W'(WINDOW - 2)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (stop_q || stop) begin
                    state_d = ST_IDLE;
                    stop_d  = 1'b0;
                end else begin
                    state_d   = ST_COLLECT;
                    win_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so grants line up with COLLECT cycles
        if (state_d == ST_COLLECT && arb_valid) begin
            grant_d = arb_gnt;
            for (int unsigned i = 0; i < NUM_SYN; i++) begin
                if (arb_gnt[i]) begin
                    syn_d = bus.weight[i*W +: W];
                end
            end
            ptr_d = (arb_idx == IDX_W'(NUM_SYN - 1)) ? '0 : arb_idx + 1'b1;
        end

        align_d = (state_d == ST_FLUSH);
        ovf_d   = align_d && (sum_d > ACC_MAX);
        busy_d  = (state_d != ST_IDLE);
        if (align_d) begin
            step_d = step_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            win_cnt_q <= '0;
            ptr_q     <= '0;
            stop_q    <= 1'b0;
            sum_q     <= '0;
            grant_q   <= '0;
            syn_q     <= '0;
            align_q   <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            ptr_q     <= ptr_d;
            stop_q    <= stop_d;
            sum_q     <= sum_d;
            grant_q   <= grant_d;
            syn_q     <= syn_d;
            align_q   <= align_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            step_q    <= step_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.syn_out  = syn_q;
    assign bus.align_en = align_q;
    assign bus.ovf      = ovf_q;
    assign busy         = busy_q;
    assign step         = step_q;

endmodule
